// File: rtl/dispatcher_pkg.sv
// Shared widths, tag constants, FSM encoding and slot/issue record types
// for the in-order dispatch stage.
package dispatcher_pkg;

    localparam int INS_OP_W  = 8;
    localparam int REG_DAT_W = 32;
    localparam int ROB_ADD_W = 5;
    localparam int REG_ADD_W = 5;

    // Tag 0 means the operand value is already available
    localparam logic [ROB_ADD_W-1:0] ROB_TAG_NONE = '0;
    localparam logic [REG_ADD_W-1:0] REG_X0       = '0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    // Contents of the single holding slot
    typedef struct packed {
        logic [INS_OP_W-1:0]  op;
        logic [31:0]          pc;
        logic [31:0]          imm;
        logic [REG_ADD_W-1:0] rd;
        logic                 is_mem;
        logic [ROB_ADD_W-1:0] q1;
        logic [REG_DAT_W-1:0] v1;
        logic [ROB_ADD_W-1:0] q2;
        logic [REG_DAT_W-1:0] v2;
        logic [ROB_ADD_W-1:0] tag;
    } slot_t;

    // Entry written into the reservation station or load/store buffer
    typedef struct packed {
        logic [INS_OP_W-1:0]  op;
        logic [31:0]          pc;
        logic [31:0]          imm;
        logic [ROB_ADD_W-1:0] qs1;
        logic [ROB_ADD_W-1:0] qs2;
        logic [REG_DAT_W-1:0] vs1;
        logic [REG_DAT_W-1:0] vs2;
        logic [ROB_ADD_W-1:0] qd;
    } issue_t;

    // A broadcast resolves an operand only when it carries a real tag
    function automatic logic bus_hit(input logic                 bus_en,
                                     input logic [ROB_ADD_W-1:0] bus_q,
                                     input logic [ROB_ADD_W-1:0] q);
        return bus_en && (q != ROB_TAG_NONE) && (bus_q == q);
    endfunction

endpackage

// File: rtl/dispatcher_operand_resolve.sv
// Single-operand merge: x0 forcing, register-file tag/value, and wake-up
// from the EX and LSB result buses (EX takes precedence).
module operand_resolve
    import dispatcher_pkg::*;
(
    input  logic                 rs_zero,
    input  logic [ROB_ADD_W-1:0] q_in,
    input  logic [REG_DAT_W-1:0] v_in,
    input  logic                 ex_en,
    input  logic [ROB_ADD_W-1:0] ex_qd,
    input  logic [REG_DAT_W-1:0] ex_vd,
    input  logic                 lsb_en,
    input  logic [ROB_ADD_W-1:0] lsb_qd,
    input  logic [REG_DAT_W-1:0] lsb_vd,
    output logic [ROB_ADD_W-1:0] q_out,
    output logic [REG_DAT_W-1:0] v_out
);

    // Priority merge of the operand sources
    always_comb begin
        q_out = q_in;
        v_out = v_in;
        if (rs_zero) begin
            q_out = ROB_TAG_NONE;
            v_out = '0;
        end else if (bus_hit(ex_en, ex_qd, q_in)) begin
            q_out = ROB_TAG_NONE;
            v_out = ex_vd;
        end else if (bus_hit(lsb_en, lsb_qd, q_in)) begin
            q_out = ROB_TAG_NONE;
            v_out = lsb_vd;
        end
    end

endmodule

// File: rtl/dispatcher.sv
// In-order dispatch stage: holds one decoded instruction, resolves its
// operands, and issues it to the RS or LSB together with ROB allocation
// and the rename-table write.
module dispatcher
    import dispatcher_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 iDC_En,
    input  logic [INS_OP_W-1:0]  iDC_Op,
    input  logic [31:0]          iDC_Pc,
    input  logic [31:0]          iDC_Imm,
    input  logic [REG_ADD_W-1:0] iDC_Rs1,
    input  logic [REG_ADD_W-1:0] iDC_Rs2,
    input  logic [REG_ADD_W-1:0] iDC_Rd,
    input  logic                 iDC_IsMem,
    output logic                 oDC_Stall,
    output logic [REG_ADD_W-1:0] oRF_Rs1,
    output logic [REG_ADD_W-1:0] oRF_Rs2,
    input  logic [ROB_ADD_W-1:0] iRF_Q1,
    input  logic [REG_DAT_W-1:0] iRF_V1,
    input  logic [ROB_ADD_W-1:0] iRF_Q2,
    input  logic [REG_DAT_W-1:0] iRF_V2,
    input  logic                 iROB_Full,
    input  logic                 iRS_Full,
    input  logic                 iLSB_Full,
    input  logic [ROB_ADD_W-1:0] iROB_Tag,
    input  logic                 iEX_En,
    input  logic [ROB_ADD_W-1:0] iEX_Qd,
    input  logic [REG_DAT_W-1:0] iEX_Vd,
    input  logic                 iLSB_En,
    input  logic [ROB_ADD_W-1:0] iLSB_Qd,
    input  logic [REG_DAT_W-1:0] iLSB_Vd,
    input  logic                 iFlush,
    output logic                 oRS_En,
    output logic [INS_OP_W-1:0]  oRS_Op,
    output logic [31:0]          oRS_Pc,
    output logic [31:0]          oRS_Imm,
    output logic [ROB_ADD_W-1:0] oRS_Qs1,
    output logic [ROB_ADD_W-1:0] oRS_Qs2,
    output logic [REG_DAT_W-1:0] oRS_Vs1,
    output logic [REG_DAT_W-1:0] oRS_Vs2,
    output logic [ROB_ADD_W-1:0] oRS_Qd,
    output logic                 oLSB_En,
    output logic [INS_OP_W-1:0]  oLSB_Op,
    output logic [31:0]          oLSB_Pc,
    output logic [31:0]          oLSB_Imm,
    output logic [ROB_ADD_W-1:0] oLSB_Qs1,
    output logic [ROB_ADD_W-1:0] oLSB_Qs2,
    output logic [REG_DAT_W-1:0] oLSB_Vs1,
    output logic [REG_DAT_W-1:0] oLSB_Vs2,
    output logic [ROB_ADD_W-1:0] oLSB_Qd,
    output logic                 oROB_En,
    output logic [INS_OP_W-1:0]  oROB_Op,
    output logic [31:0]          oROB_Pc,
    output logic [REG_ADD_W-1:0] oROB_Rd,
    output logic                 oRF_En,
    output logic [REG_ADD_W-1:0] oRF_Rd,
    output logic [ROB_ADD_W-1:0] oRF_Tag
);

    state_e state_q, state_d;
    slot_t  slot_q,  slot_d;
    issue_t rs_issue_q,  rs_issue_d;
    issue_t lsb_issue_q, lsb_issue_d;
    logic   rs_en_q,  rs_en_d;
    logic   lsb_en_q, lsb_en_d;
    logic   rob_en_q, rob_en_d;
    logic   rf_en_q,  rf_en_d;
    logic [INS_OP_W-1:0]  rob_op_q,  rob_op_d;
    logic [31:0]          rob_pc_q,  rob_pc_d;
    logic [REG_ADD_W-1:0] rob_rd_q,  rob_rd_d;
    logic [REG_ADD_W-1:0] rf_rd_q,   rf_rd_d;
    logic [ROB_ADD_W-1:0] rf_tag_q,  rf_tag_d;

    logic   go;
    logic   latch;
    issue_t issue_next;

    // Operand resolution arrays: index 0 = rs1, index 1 = rs2
    logic [1:0]           lat_rs_zero;
    logic [ROB_ADD_W-1:0] lat_q_in   [2];
    logic [REG_DAT_W-1:0] lat_v_in   [2];
    logic [ROB_ADD_W-1:0] lat_q_out  [2];
    logic [REG_DAT_W-1:0] lat_v_out  [2];
    logic [ROB_ADD_W-1:0] hold_q_in  [2];
    logic [REG_DAT_W-1:0] hold_v_in  [2];
    logic [ROB_ADD_W-1:0] hold_q_out [2];
    logic [REG_DAT_W-1:0] hold_v_out [2];

    assign oRF_Rs1 = iDC_Rs1;
    assign oRF_Rs2 = iDC_Rs2;

    assign lat_rs_zero[0] = (iDC_Rs1 == REG_X0);
    assign lat_rs_zero[1] = (iDC_Rs2 == REG_X0);
    assign lat_q_in[0]    = iRF_Q1;
    assign lat_q_in[1]    = iRF_Q2;
    assign lat_v_in[0]    = iRF_V1;
    assign lat_v_in[1]    = iRF_V2;
    assign hold_q_in[0]   = slot_q.q1;
    assign hold_q_in[1]   = slot_q.q2;
    assign hold_v_in[0]   = slot_q.v1;
    assign hold_v_in[1]   = slot_q.v2;

    // Latch path resolves incoming operands; hold path snoops the slot
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            operand_resolve u_latch (
                .rs_zero (lat_rs_zero[gi]),
                .q_in    (lat_q_in[gi]),
                .v_in    (lat_v_in[gi]),
                .ex_en   (iEX_En),
                .ex_qd   (iEX_Qd),
                .ex_vd   (iEX_Vd),
                .lsb_en  (iLSB_En),
                .lsb_qd  (iLSB_Qd),
                .lsb_vd  (iLSB_Vd),
                .q_out   (lat_q_out[gi]),
                .v_out   (lat_v_out[gi])
            );
            operand_resolve u_hold (
                .rs_zero (1'b0),
                .q_in    (hold_q_in[gi]),
                .v_in    (hold_v_in[gi]),
                .ex_en   (iEX_En),
                .ex_qd   (iEX_Qd),
                .ex_vd   (iEX_Vd),
                .lsb_en  (iLSB_En),
                .lsb_qd  (iLSB_Qd),
                .lsb_vd  (iLSB_Vd),
                .q_out   (hold_q_out[gi]),
                .v_out   (hold_v_out[gi])
            );
        end
    endgenerate

    // Dispatch/latch decisions and the decoder handshake
    always_comb begin
        go = en && (state_q == ST_HOLD) && !iROB_Full && !iFlush &&
             (slot_q.is_mem ? !iLSB_Full : !iRS_Full);
        latch = en && !iFlush && iDC_En && ((state_q == ST_EMPTY) || go);
        oDC_Stall = (state_q == ST_HOLD) && !go;

        // Outgoing operands carry this cycle's bus wake-ups
        issue_next.op  = slot_q.op;
        issue_next.pc  = slot_q.pc;
        issue_next.imm = slot_q.imm;
        issue_next.qs1 = hold_q_out[0];
        issue_next.qs2 = hold_q_out[1];
        issue_next.vs1 = hold_v_out[0];
        issue_next.vs2 = hold_v_out[1];
        issue_next.qd  = slot_q.tag;
    end

    // Next-state for the FSM, the slot and all registered outputs
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        if (en) begin
            if (iFlush) begin
                state_d = ST_EMPTY;
            end else if (latch) begin
                state_d       = ST_HOLD;
                slot_d.op     = iDC_Op;
                slot_d.pc     = iDC_Pc;
                slot_d.imm    = iDC_Imm;
                slot_d.rd     = iDC_Rd;
                slot_d.is_mem = iDC_IsMem;
                slot_d.q1     = lat_q_out[0];
                slot_d.v1     = lat_v_out[0];
                slot_d.q2     = lat_q_out[1];
                slot_d.v2     = lat_v_out[1];
                slot_d.tag    = iROB_Tag;
            end else if (go) begin
                state_d = ST_EMPTY;
            end else if (state_q == ST_HOLD) begin
                slot_d.q1 = hold_q_out[0];
                slot_d.v1 = hold_v_out[0];
                slot_d.q2 = hold_q_out[1];
                slot_d.v2 = hold_v_out[1];
            end
        end

        rs_en_d  = go && !slot_q.is_mem;
        lsb_en_d = go && slot_q.is_mem;
        rob_en_d = go;
        rf_en_d  = go && (slot_q.rd != REG_X0);

        rs_issue_d  = rs_en_d  ? issue_next : rs_issue_q;
        lsb_issue_d = lsb_en_d ? issue_next : lsb_issue_q;
        rob_op_d    = go ? slot_q.op : rob_op_q;
        rob_pc_d    = go ? slot_q.pc : rob_pc_q;
        rob_rd_d    = go ? slot_q.rd : rob_rd_q;
        rf_rd_d     = rf_en_d ? slot_q.rd  : rf_rd_q;
        rf_tag_d    = rf_en_d ? slot_q.tag : rf_tag_q;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            slot_q      <= '0;
            rs_issue_q  <= '0;
            lsb_issue_q <= '0;
            rs_en_q     <= 1'b0;
            lsb_en_q    <= 1'b0;
            rob_en_q    <= 1'b0;
            rf_en_q     <= 1'b0;
            rob_op_q    <= '0;
            rob_pc_q    <= '0;
            rob_rd_q    <= '0;
            rf_rd_q     <= '0;
            rf_tag_q    <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            rs_issue_q  <= rs_issue_d;
            lsb_issue_q <= lsb_issue_d;
            rs_en_q     <= rs_en_d;
            lsb_en_q    <= lsb_en_d;
            rob_en_q    <= rob_en_d;
            rf_en_q     <= rf_en_d;
            rob_op_q    <= rob_op_d;
            rob_pc_q    <= rob_pc_d;
            rob_rd_q    <= rob_rd_d;
            rf_rd_q     <= rf_rd_d;
            rf_tag_q    <= rf_tag_d;
        end
    end

    // Enables are additionally masked so a stalled back end never sees a write
    assign oRS_En   = rs_en_q  && en;
    assign oLSB_En  = lsb_en_q && en;
    assign oROB_En  = rob_en_q && en;
    assign oRF_En   = rf_en_q  && en;

    assign oRS_Op   = rs_issue_q.op;
    assign oRS_Pc   = rs_issue_q.pc;
    assign oRS_Imm  = rs_issue_q.imm;
    assign oRS_Qs1  = rs_issue_q.qs1;
    assign oRS_Qs2  = rs_issue_q.qs2;
    assign oRS_Vs1  = rs_issue_q.vs1;
    assign oRS_Vs2  = rs_issue_q.vs2;
    assign oRS_Qd   = rs_issue_q.qd;

    assign oLSB_Op  = lsb_issue_q.op;
    assign oLSB_Pc  = lsb_issue_q.pc;
    assign oLSB_Imm = lsb_issue_q.imm;
    assign oLSB_Qs1 = lsb_issue_q.qs1;
    assign oLSB_Qs2 = lsb_issue_q.qs2;
    assign oLSB_Vs1 = lsb_issue_q.vs1;
    assign oLSB_Vs2 = lsb_issue_q.vs2;
    assign oLSB_Qd  = lsb_issue_q.qd;

    assign oROB_Op  = rob_op_q;
    assign oROB_Pc  = rob_pc_q;
    assign oROB_Rd  = rob_rd_q;
    assign oRF_Rd   = rf_rd_q;
    assign oRF_Tag  = rf_tag_q;

endmodule

// File: tb/tb_dispatcher.sv
// Directed bench for the dispatch stage with hand-computed expectations.
module tb_dispatcher;
    import dispatcher_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 en;
    logic                 iDC_En;
    logic [INS_OP_W-1:0]  iDC_Op;
    logic [31:0]          iDC_Pc;
    logic [31:0]          iDC_Imm;
    logic [REG_ADD_W-1:0] iDC_Rs1;
    logic [REG_ADD_W-1:0] iDC_Rs2;
    logic [REG_ADD_W-1:0] iDC_Rd;
    logic                 iDC_IsMem;
    logic                 oDC_Stall;
    logic [REG_ADD_W-1:0] oRF_Rs1;
    logic [REG_ADD_W-1:0] oRF_Rs2;
    logic [ROB_ADD_W-1:0] iRF_Q1;
    logic [REG_DAT_W-1:0] iRF_V1;
    logic [ROB_ADD_W-1:0] iRF_Q2;
    logic [REG_DAT_W-1:0] iRF_V2;
    logic                 iROB_Full;
    logic                 iRS_Full;
    logic                 iLSB_Full;
    logic [ROB_ADD_W-1:0] iROB_Tag;
    logic                 iEX_En;
    logic [ROB_ADD_W-1:0] iEX_Qd;
    logic [REG_DAT_W-1:0] iEX_Vd;
    logic                 iLSB_En;
    logic [ROB_ADD_W-1:0] iLSB_Qd;
    logic [REG_DAT_W-1:0] iLSB_Vd;
    logic                 iFlush;
    logic                 oRS_En;
    logic [INS_OP_W-1:0]  oRS_Op;
    logic [31:0]          oRS_Pc;
    logic [31:0]          oRS_Imm;
    logic [ROB_ADD_W-1:0] oRS_Qs1;
    logic [ROB_ADD_W-1:0] oRS_Qs2;
    logic [REG_DAT_W-1:0] oRS_Vs1;
    logic [REG_DAT_W-1:0] oRS_Vs2;
    logic [ROB_ADD_W-1:0] oRS_Qd;
    logic                 oLSB_En;
    logic [INS_OP_W-1:0]  oLSB_Op;
    logic [31:0]          oLSB_Pc;
    logic [31:0]          oLSB_Imm;
    logic [ROB_ADD_W-1:0] oLSB_Qs1;
    logic [ROB_ADD_W-1:0] oLSB_Qs2;
    logic [REG_DAT_W-1:0] oLSB_Vs1;
    logic [REG_DAT_W-1:0] oLSB_Vs2;
    logic [ROB_ADD_W-1:0] oLSB_Qd;
    logic                 oROB_En;
    logic [INS_OP_W-1:0]  oROB_Op;
    logic [31:0]          oROB_Pc;
    logic [REG_ADD_W-1:0] oROB_Rd;
    logic                 oRF_En;
    logic [REG_ADD_W-1:0] oRF_Rd;
    logic [ROB_ADD_W-1:0] oRF_Tag;

    int errors = 0;
    int checks = 0;

    dispatcher dut (
        .clk(clk), .rst(rst), .en(en),
        .iDC_En(iDC_En), .iDC_Op(iDC_Op), .iDC_Pc(iDC_Pc), .iDC_Imm(iDC_Imm),
        .iDC_Rs1(iDC_Rs1), .iDC_Rs2(iDC_Rs2), .iDC_Rd(iDC_Rd), .iDC_IsMem(iDC_IsMem),
        .oDC_Stall(oDC_Stall), .oRF_Rs1(oRF_Rs1), .oRF_Rs2(oRF_Rs2),
        .iRF_Q1(iRF_Q1), .iRF_V1(iRF_V1), .iRF_Q2(iRF_Q2), .iRF_V2(iRF_V2),
        .iROB_Full(iROB_Full), .iRS_Full(iRS_Full), .iLSB_Full(iLSB_Full),
        .iROB_Tag(iROB_Tag),
        .iEX_En(iEX_En), .iEX_Qd(iEX_Qd), .iEX_Vd(iEX_Vd),
        .iLSB_En(iLSB_En), .iLSB_Qd(iLSB_Qd), .iLSB_Vd(iLSB_Vd),
        .iFlush(iFlush),
        .oRS_En(oRS_En), .oRS_Op(oRS_Op), .oRS_Pc(oRS_Pc), .oRS_Imm(oRS_Imm),
        .oRS_Qs1(oRS_Qs1), .oRS_Qs2(oRS_Qs2), .oRS_Vs1(oRS_Vs1), .oRS_Vs2(oRS_Vs2),
        .oRS_Qd(oRS_Qd),
        .oLSB_En(oLSB_En), .oLSB_Op(oLSB_Op), .oLSB_Pc(oLSB_Pc), .oLSB_Imm(oLSB_Imm),
        .oLSB_Qs1(oLSB_Qs1), .oLSB_Qs2(oLSB_Qs2), .oLSB_Vs1(oLSB_Vs1), .oLSB_Vs2(oLSB_Vs2),
        .oLSB_Qd(oLSB_Qd),
        .oROB_En(oROB_En), .oROB_Op(oROB_Op), .oROB_Pc(oROB_Pc), .oROB_Rd(oROB_Rd),
        .oRF_En(oRF_En), .oRF_Rd(oRF_Rd), .oRF_Tag(oRF_Tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iDC_En = 1'b0; iDC_Op = '0; iDC_Pc = '0; iDC_Imm = '0;
        iDC_Rs1 = '0; iDC_Rs2 = '0; iDC_Rd = '0; iDC_IsMem = 1'b0;
        iRF_Q1 = '0; iRF_V1 = '0; iRF_Q2 = '0; iRF_V2 = '0;
        iEX_En = 1'b0; iEX_Qd = '0; iEX_Vd = '0;
        iLSB_En = 1'b0; iLSB_Qd = '0; iLSB_Vd = '0;
    endtask

    task automatic present(input logic [7:0] op, input logic [31:0] pc,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic is_mem,
                           input logic [4:0] q1, input logic [31:0] v1,
                           input logic [4:0] q2, input logic [31:0] v2,
                           input logic [4:0] tag);
        iDC_En = 1'b1; iDC_Op = op; iDC_Pc = pc; iDC_Imm = pc + 32'd4;
        iDC_Rs1 = rs1; iDC_Rs2 = rs2; iDC_Rd = rd; iDC_IsMem = is_mem;
        iRF_Q1 = q1; iRF_V1 = v1; iRF_Q2 = q2; iRF_V2 = v2; iROB_Tag = tag;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; iFlush = 1'b0;
        iROB_Full = 1'b0; iRS_Full = 1'b0; iLSB_Full = 1'b0; iROB_Tag = 5'd1;
        idle();

        // Reset state
        tick(); tick();
        chk("rst_rs_en", 32'(oRS_En), 32'd0);
        chk("rst_lsb_en", 32'(oLSB_En), 32'd0);
        chk("rst_rob_en", 32'(oROB_En), 32'd0);
        chk("rst_rf_en", 32'(oRF_En), 32'd0);
        chk("rst_rs_qd", 32'(oRS_Qd), 32'd0);
        chk("rst_rs_vs1", oRS_Vs1, 32'd0);
        chk("rst_stall", 32'(oDC_Stall), 32'd0);
        rst = 1'b1;

        // Basic ALU op: rs1=x3 ready with 7, rs2=x0 (regfile garbage ignored)
        present(8'h12, 32'h100, 5'd3, 5'd0, 5'd5, 1'b0, 5'd0, 32'd7, 5'd3, 32'h99, 5'd4);
        #1;
        chk("rf_lookup_rs1", 32'(oRF_Rs1), 32'd3);
        tick();
        idle();
        #1;
        chk("t1_stall", 32'(oDC_Stall), 32'd0);
        chk("t1_no_early", 32'(oRS_En), 32'd0);
        tick();
        chk("t1_rs_en", 32'(oRS_En), 32'd1);
        chk("t1_lsb_en", 32'(oLSB_En), 32'd0);
        chk("t1_rob_en", 32'(oROB_En), 32'd1);
        chk("t1_vs1", oRS_Vs1, 32'd7);
        chk("t1_qs1", 32'(oRS_Qs1), 32'd0);
        chk("t1_qs2", 32'(oRS_Qs2), 32'd0);
        chk("t1_vs2", oRS_Vs2, 32'd0);
        chk("t1_qd", 32'(oRS_Qd), 32'd4);
        chk("t1_op", 32'(oRS_Op), 32'h12);
        chk("t1_rf_en", 32'(oRF_En), 32'd1);
        chk("t1_rf_tag", 32'(oRF_Tag), 32'd4);
        chk("t1_rf_rd", 32'(oRF_Rd), 32'd5);
        chk("t1_rob_pc", oROB_Pc, 32'h100);
        tick();
        chk("t1_pulse_end", 32'(oRS_En), 32'd0);

        // EX bus resolves a pending rs1 in the latch cycle
        present(8'h21, 32'h200, 5'd2, 5'd4, 5'd1, 1'b0, 5'd6, 32'd0, 5'd0, 32'h22, 5'd7);
        iEX_En = 1'b1; iEX_Qd = 5'd6; iEX_Vd = 32'h55;
        tick();
        idle();
        tick();
        chk("t2_rs_en", 32'(oRS_En), 32'd1);
        chk("t2_qs1", 32'(oRS_Qs1), 32'd0);
        chk("t2_vs1", oRS_Vs1, 32'h55);
        chk("t2_vs2", oRS_Vs2, 32'h22);
        chk("t2_qd", 32'(oRS_Qd), 32'd7);

        // RS full for three cycles; LSB bus wakes rs2 during the stall
        present(8'h33, 32'h300, 5'd0, 5'd8, 5'd2, 1'b0, 5'd0, 32'd0, 5'd9, 32'd0, 5'd8);
        tick();
        idle();
        iRS_Full = 1'b1;
        iLSB_En = 1'b1; iLSB_Qd = 5'd9; iLSB_Vd = 32'h11;
        #1;
        chk("t3_stall_c1", 32'(oDC_Stall), 32'd1);
        tick();
        iLSB_En = 1'b0; iLSB_Qd = '0; iLSB_Vd = '0;
        #1;
        chk("t3_stall_c2", 32'(oDC_Stall), 32'd1);
        chk("t3_held", 32'(oRS_En), 32'd0);
        tick();
        chk("t3_stall_c3", 32'(oDC_Stall), 32'd1);
        tick();
        iRS_Full = 1'b0;
        #1;
        chk("t3_release", 32'(oDC_Stall), 32'd0);
        tick();
        chk("t3_rs_en", 32'(oRS_En), 32'd1);
        chk("t3_qs2", 32'(oRS_Qs2), 32'd0);
        chk("t3_vs2", oRS_Vs2, 32'h11);
        chk("t3_qd", 32'(oRS_Qd), 32'd8);

        // Load with rd=x0 goes to the LSB without a rename write
        present(8'h44, 32'h400, 5'd1, 5'd0, 5'd0, 1'b1, 5'd0, 32'h40, 5'd0, 32'd0, 5'd10);
        tick();
        idle();
        tick();
        chk("t4_lsb_en", 32'(oLSB_En), 32'd1);
        chk("t4_rs_en", 32'(oRS_En), 32'd0);
        chk("t4_rob_en", 32'(oROB_En), 32'd1);
        chk("t4_rf_en", 32'(oRF_En), 32'd0);
        chk("t4_vs1", oLSB_Vs1, 32'h40);
        chk("t4_qd", 32'(oLSB_Qd), 32'd10);
        chk("t4_rob_rd", 32'(oROB_Rd), 32'd0);

        // Flush of a held instruction; a same-cycle new instruction is dropped
        present(8'h55, 32'h500, 5'd0, 5'd0, 5'd3, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd11);
        tick();
        present(8'h56, 32'h504, 5'd0, 5'd0, 5'd3, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd12);
        iFlush = 1'b1;
        #1;
        chk("t5_stall_fl", 32'(oDC_Stall), 32'd1);
        tick();
        iFlush = 1'b0;
        idle();
        #1;
        chk("t5_rs_en", 32'(oRS_En), 32'd0);
        chk("t5_rob_en", 32'(oROB_En), 32'd0);
        chk("t5_rf_en", 32'(oRF_En), 32'd0);
        chk("t5_stall", 32'(oDC_Stall), 32'd0);
        tick();
        chk("t5_discard", 32'(oRS_En), 32'd0);
        chk("t5_discard_rb", 32'(oROB_En), 32'd0);

        // Four back-to-back instructions, one dispatch per cycle
        present(8'h61, 32'h600, 5'd0, 5'd0, 5'd1, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1);
        #1;
        chk("t6_stall_0", 32'(oDC_Stall), 32'd0);
        tick();
        present(8'h62, 32'h604, 5'd0, 5'd0, 5'd2, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd2);
        #1;
        chk("t6_stall_1", 32'(oDC_Stall), 32'd0);
        tick();
        chk("t6_en_1", 32'(oRS_En), 32'd1);
        chk("t6_tag_1", 32'(oRS_Qd), 32'd1);
        present(8'h63, 32'h608, 5'd0, 5'd0, 5'd3, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3);
        tick();
        chk("t6_en_2", 32'(oRS_En), 32'd1);
        chk("t6_tag_2", 32'(oRS_Qd), 32'd2);
        present(8'h64, 32'h60c, 5'd0, 5'd0, 5'd4, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd4);
        tick();
        chk("t6_en_3", 32'(oRS_En), 32'd1);
        chk("t6_tag_3", 32'(oRS_Qd), 32'd3);
        idle();
        tick();
        chk("t6_en_4", 32'(oRS_En), 32'd1);
        chk("t6_tag_4", 32'(oRS_Qd), 32'd4);
        chk("t6_op_4", 32'(oRS_Op), 32'h64);
        tick();
        chk("t6_en_end", 32'(oRS_En), 32'd0);

        // en=0 freezes the slot: no dispatch and no snoop
        present(8'h71, 32'h700, 5'd6, 5'd0, 5'd4, 1'b0, 5'd12, 32'd3, 5'd0, 32'd0, 5'd14);
        tick();
        idle();
        en = 1'b0;
        iEX_En = 1'b1; iEX_Qd = 5'd12; iEX_Vd = 32'h77;
        #1;
        chk("t7_stall", 32'(oDC_Stall), 32'd1);
        tick();
        chk("t7_frozen_1", 32'(oRS_En), 32'd0);
        tick();
        chk("t7_frozen_2", 32'(oRS_En), 32'd0);
        en = 1'b1;
        iEX_En = 1'b0; iEX_Qd = '0; iEX_Vd = '0;
        tick();
        chk("t7_rs_en", 32'(oRS_En), 32'd1);
        chk("t7_qs1", 32'(oRS_Qs1), 32'd12);
        chk("t7_vs1", oRS_Vs1, 32'd3);
        chk("t7_qd", 32'(oRS_Qd), 32'd14);

        // Both buses match the same tag: EX value wins
        present(8'h81, 32'h800, 5'd7, 5'd0, 5'd6, 1'b0, 5'd13, 32'd0, 5'd0, 32'd0, 5'd15);
        iEX_En = 1'b1; iEX_Qd = 5'd13; iEX_Vd = 32'hA;
        iLSB_En = 1'b1; iLSB_Qd = 5'd13; iLSB_Vd = 32'hB;
        tick();
        idle();
        tick();
        chk("t8_rs_en", 32'(oRS_En), 32'd1);
        chk("t8_qs1", 32'(oRS_Qs1), 32'd0);
        chk("t8_vs1", oRS_Vs1, 32'hA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
